// File: rtl/fifo_rr_write_arbiter_if.sv
// fifo_rr_write_arbiter_if
//   Bundles the producer streams and the FIFO write port of the round-robin
//   write arbiter. The arbiter connects through the slave modport; the
//   environment (producers + FIFO model) uses the master modport.
//   Signals:
//     req_valid/req_data/req_last  producer words, lane i at [i*DATA_W +: DATA_W]
//     req_ready                    per-producer accept (at most one bit set)
//     fifo_full                    FIFO full flag
//     fifo_w_req/fifo_w_data       FIFO write strobe and data
//     grant_valid/grant_id         current grant status
//     burst_cnt                    words accepted in the current grant
//     timeout_evt                  pulse when a grant is revoked by timeout
interface fifo_rr_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2,
  parameter int CNT_W  = 3
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_full;
  logic                    fifo_w_req;
  logic [DATA_W-1:0]       fifo_w_data;
  logic                    grant_valid;
  logic [ID_W-1:0]         grant_id;
  logic [CNT_W-1:0]        burst_cnt;
  logic                    timeout_evt;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_w_req, fifo_w_data,
    output grant_valid, grant_id, burst_cnt, timeout_evt
  );

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_w_req, fifo_w_data,
    input  grant_valid, grant_id, burst_cnt, timeout_evt
  );
endinterface

// File: rtl/fifo_rr_write_arbiter.sv
// fifo_rr_write_arbiter
//   Shares one FIFO write port among N_REQ valid/ready producers using
//   round-robin arbitration with bursts bounded by BURST_MAX words and a
//   grant revoked after IDLE_TIMEOUT idle cycles.
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   fifo_rr_write_arbiter_if.slave (producer streams + FIFO write port)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no grant; search req_valid from rr_ptr (one dead cycle)
//   GRANT  | grant_id owns the write port until last / burst / timeout
module fifo_rr_write_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 32,
  parameter int BURST_MAX    = 4,
  parameter int IDLE_TIMEOUT = 8,
  parameter int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W        = ((BURST_MAX > 1) ? $clog2(BURST_MAX) : 1) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  fifo_rr_write_arbiter_if.slave     bus
);

  localparam int TMR_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   gid, gid_nxt;
  logic [CNT_W-1:0]  bcnt, bcnt_nxt;
  // Idle timer counts down from IDLE_TIMEOUT-1; zero marks the last idle
  // cycle the grant is allowed.
  logic [TMR_W-1:0]  idle_tmr, idle_tmr_nxt;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   cand;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic              in_grant;
  logic              g_valid;
  logic              g_last;
  logic              xfer;
  logic              tmr_done;
  logic              rel_done;
  logic              timeout;
  logic [ID_W-1:0]   ptr_after;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  // Rotating priority search: first valid requester at or after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign in_grant  = (state == S_GRANT);
  assign g_valid   = bus.req_valid[gid];
  assign g_last    = bus.req_last[gid];
  assign xfer      = in_grant & g_valid & ~bus.fifo_full;
  assign tmr_done  = (idle_tmr == '0);
  assign rel_done  = xfer & (g_last | (bcnt == CNT_W'(BURST_MAX - 1)));
  // xfer needs valid high, so a last/burst release can never overlap this.
  assign timeout   = in_grant & ~g_valid & tmr_done;
  assign ptr_after = (gid == ID_W'(N_REQ - 1)) ? '0 : gid + ID_W'(1);

  // Write path is purely combinational so the FIFO captures on the same edge.
  always_comb begin
    bus.req_ready = '0;
    if (in_grant && !bus.fifo_full) begin
      bus.req_ready[gid] = 1'b1;
    end
  end

  assign bus.fifo_w_req  = xfer;
  assign bus.fifo_w_data = in_grant ? data_arr[gid] : '0;
  assign bus.grant_valid = in_grant;
  assign bus.grant_id    = gid;
  assign bus.burst_cnt   = bcnt;
  assign bus.timeout_evt = timeout;

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    gid_nxt      = gid;
    bcnt_nxt     = bcnt;
    idle_tmr_nxt = idle_tmr;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nxt    = S_GRANT;
          gid_nxt      = win_id;
          bcnt_nxt     = '0;
          idle_tmr_nxt = TMR_W'(IDLE_TIMEOUT - 1);
        end
      end
      S_GRANT: begin
        if (xfer) begin
          bcnt_nxt     = bcnt + CNT_W'(1);
          idle_tmr_nxt = TMR_W'(IDLE_TIMEOUT - 1);
          if (rel_done) begin
            state_nxt  = S_IDLE;
            rr_ptr_nxt = ptr_after;
          end
        end else if (!g_valid) begin
          if (tmr_done) begin
            state_nxt  = S_IDLE;
            rr_ptr_nxt = ptr_after;
          end else begin
            idle_tmr_nxt = idle_tmr - TMR_W'(1);
          end
        end
        // valid but stalled by fifo_full: hold everything
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      gid      <= '0;
      bcnt     <= '0;
      idle_tmr <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      gid      <= gid_nxt;
      bcnt     <= bcnt_nxt;
      idle_tmr <= idle_tmr_nxt;
    end
  end

endmodule
